// File: rtl/pwm_fader_multi_if.sv
// Write-command bus for pwm_fader_multi.
// wr_en is a one-cycle strobe with no ready: every write is accepted at the
// clock edge where wr_en is high, and there is no backpressure.
`timescale 1ns/1ps
interface pwm_fader_multi_if #(
  parameter int WIDTH = 8
);
  logic             wr_en;
  logic [2:0]       wr_chan;
  logic [WIDTH-1:0] wr_level;
  logic [1:0]       wr_mode;

  modport master (output wr_en, output wr_chan, output wr_level, output wr_mode);
  modport slave  (input  wr_en, input  wr_chan, input  wr_level, input  wr_mode);
endinterface

// File: rtl/pwm_fader_multi.sv
// N-channel LED fader: per-channel target/mode registers, a tick-paced level
// ramp (fade, breathe triangle or snap) and a counter-compare PWM output.
`timescale 1ns/1ps
module pwm_fader_multi #(
  parameter int CHANNELS   = 3,
  parameter int WIDTH      = 8,
  parameter int PREDIVIDER = 12
) (
  input  logic                      clk,
  input  logic                      resetq,
  pwm_fader_multi_if.slave          wr,
  output logic [CHANNELS-1:0]       pwm,
  output logic [CHANNELS*WIDTH-1:0] level,
  output logic [CHANNELS-1:0]       settled
);

  localparam logic [1:0] MODE_BREATHE = 2'd1;
  localparam logic [1:0] MODE_SNAP    = 2'd2;

  localparam logic [WIDTH-1:0]      L_ONE = WIDTH'(1);
  localparam logic [PREDIVIDER-1:0] P_ONE = PREDIVIDER'(1);

  logic [WIDTH-1:0]      r_cnt;
  logic [PREDIVIDER-1:0] r_presc;
  logic                  w_tick;

  logic [WIDTH-1:0]      r_level  [CHANNELS];
  logic [WIDTH-1:0]      r_target [CHANNELS];
  logic [1:0]            r_mode   [CHANNELS];
  logic [CHANNELS-1:0]   r_dir;      // 1 = rising half of the breathe triangle
  logic [CHANNELS-1:0]   r_pwm;

  logic [WIDTH-1:0]      w_step_level [CHANNELS];
  logic [CHANNELS-1:0]   w_step_dir;
  logic [CHANNELS-1:0]   w_hit;

  // Free-running PWM counter and fade prescaler, both cleared by reset.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      r_cnt   <= '0;
      r_presc <= '0;
    end else begin
      r_cnt   <= r_cnt + L_ONE;
      r_presc <= r_presc + P_ONE;
    end
  end

  assign w_tick = &r_presc;

  // Next level/direction per channel from the current (old) target and mode.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      w_step_level[i] = r_level[i];
      w_step_dir[i]   = r_dir[i];
      // Full 3-bit compare so out-of-range channel indices never hit.
      w_hit[i]        = wr.wr_en && (wr.wr_chan == 3'(i));
      if (w_tick) begin
        case (r_mode[i])
          MODE_SNAP: begin
            w_step_level[i] = r_level[i];
          end
          MODE_BREATHE: begin
            if (r_dir[i]) begin
              if (r_level[i] < r_target[i]) begin
                w_step_level[i] = r_level[i] + L_ONE;
              end else begin
                w_step_dir[i] = 1'b0;
                if (r_level[i] != '0) w_step_level[i] = r_level[i] - L_ONE;
              end
            end else begin
              if (r_level[i] != '0) begin
                w_step_level[i] = r_level[i] - L_ONE;
              end else begin
                w_step_dir[i] = 1'b1;
                if (r_target[i] != '0) w_step_level[i] = r_level[i] + L_ONE;
              end
            end
          end
          default: begin
            // FADE and the reserved mode share the plain ramp.
            if (r_level[i] < r_target[i]) begin
              w_step_level[i] = r_level[i] + L_ONE;
            end else if (r_level[i] > r_target[i]) begin
              w_step_level[i] = r_level[i] - L_ONE;
            end
          end
        endcase
      end
    end
  end

  // Channel state: tick step, then a same-cycle write overrides target/mode
  // (and level for SNAP), so a colliding tick always used the old values.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_level[i]  <= '0;
        r_target[i] <= '0;
        r_mode[i]   <= '0;
      end
      r_dir <= '1;
      r_pwm <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        r_pwm[i]   <= (r_cnt < r_level[i]);
        r_level[i] <= w_step_level[i];
        r_dir[i]   <= w_step_dir[i];
        if (w_hit[i]) begin
          r_target[i] <= wr.wr_level;
          r_mode[i]   <= wr.wr_mode;
          if (wr.wr_mode == MODE_BREATHE) r_dir[i]   <= 1'b1;
          if (wr.wr_mode == MODE_SNAP)    r_level[i] <= wr.wr_level;
        end
      end
    end
  end

  assign pwm = r_pwm;

  // Flatten levels and derive settled from registered state.
  always_comb begin
    level   = '0;
    settled = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      level[i*WIDTH +: WIDTH] = r_level[i];
      settled[i] = (r_level[i] == r_target[i]) && (r_mode[i] != MODE_BREATHE);
    end
  end

endmodule

// File: tb/tb_pwm_fader_multi.sv
// Self-checking bench for pwm_fader_multi: a cycle model of the channel rules
// compared every cycle, plus directed checks with hand-computed values.
`timescale 1ns/1ps
module tb_pwm_fader_multi;

  localparam int CH  = 3;
  localparam int W   = 8;
  localparam int PRE = 2;
  localparam int W4  = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetq = 1'b0;
  always #5 clk = ~clk;

  pwm_fader_multi_if #(.WIDTH(W))  bus ();
  pwm_fader_multi_if #(.WIDTH(W4)) bus4 ();

  logic [CH-1:0]   pwm;
  logic [CH*W-1:0] level;
  logic [CH-1:0]   settled;
  logic [0:0]      pwm4;
  logic [W4-1:0]   level4;
  logic [0:0]      settled4;

  pwm_fader_multi #(.CHANNELS(CH), .WIDTH(W), .PREDIVIDER(PRE)) u_dut (
    .clk     (clk),
    .resetq  (resetq),
    .wr      (bus),
    .pwm     (pwm),
    .level   (level),
    .settled (settled)
  );

  pwm_fader_multi #(.CHANNELS(1), .WIDTH(W4), .PREDIVIDER(PRE)) u_dut4 (
    .clk     (clk),
    .resetq  (resetq),
    .wr      (bus4),
    .pwm     (pwm4),
    .level   (level4),
    .settled (settled4)
  );

  // ---------------- scoreboard counters ----------------
  int errors = 0;
  int checks = 0;
  int fail_prints = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (fail_prints < 60) begin
        fail_prints++;
        $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      if (fail_prints < 60) begin
        fail_prints++;
        $display("FAIL %s: got %0d expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
      end
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_cyc;            // clocks since reset release: drives both counters
  int m_lvl  [CH];
  int m_tgt  [CH];
  int m_mode [CH];
  bit m_up   [CH];
  bit [CH-1:0] m_pwm;
  bit m_init = 1'b0;

  function automatic void model_tick(input int i);
    case (m_mode[i])
      2: ;
      1: begin
        // Turn around at the ends of the triangle, then move one step.
        if (m_up[i] && m_lvl[i] >= m_tgt[i]) m_up[i] = 1'b0;
        else if (!m_up[i] && m_lvl[i] == 0) m_up[i] = 1'b1;
        if (m_up[i]) begin
          if (m_lvl[i] < m_tgt[i]) m_lvl[i]++;
        end else if (m_lvl[i] > 0) begin
          m_lvl[i]--;
        end
      end
      default: begin
        if (m_lvl[i] < m_tgt[i]) m_lvl[i]++;
        else if (m_lvl[i] > m_tgt[i]) m_lvl[i]--;
      end
    endcase
  endfunction

  always @(posedge clk or negedge resetq) begin : model_blk
    bit tick;
    int cnt;
    int ch;
    if (!resetq) begin
      m_cyc = 0;
      m_pwm = '0;
      for (int i = 0; i < CH; i++) begin
        m_lvl[i] = 0; m_tgt[i] = 0; m_mode[i] = 0; m_up[i] = 1'b1;
      end
      m_init = 1'b1;
    end else begin
      tick = (m_cyc % (1 << PRE)) == ((1 << PRE) - 1);
      cnt  = m_cyc % (1 << W);
      for (int i = 0; i < CH; i++) m_pwm[i] = (cnt < m_lvl[i]);
      if (tick) for (int i = 0; i < CH; i++) model_tick(i);
      ch = int'(bus.wr_chan);
      if (bus.wr_en === 1'b1 && ch < CH) begin
        m_tgt[ch]  = int'(bus.wr_level);
        m_mode[ch] = int'(bus.wr_mode);
        if (m_mode[ch] == 1) m_up[ch] = 1'b1;
        if (m_mode[ch] == 2) m_lvl[ch] = m_tgt[ch];
      end
      m_cyc++;
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (m_init) begin
      for (int i = 0; i < CH; i++) begin
        chk($sformatf("model_pwm%0d", i), int'(pwm[i]), int'(m_pwm[i]));
        chk($sformatf("model_level%0d", i), int'(level[i*W +: W]), m_lvl[i]);
        chk($sformatf("model_settled%0d", i), int'(settled[i]),
            int'(m_lvl[i] == m_tgt[i] && m_mode[i] != 1));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wr(input int ch, input int lvl, input int md);
    bus.wr_en    = 1'b1;
    bus.wr_chan  = 3'(ch);
    bus.wr_level = W'(lvl);
    bus.wr_mode  = 2'(md);
    @(negedge clk);
    bus.wr_en    = 1'b0;
  endtask

  task automatic wr4(input int lvl, input int md);
    bus4.wr_en    = 1'b1;
    bus4.wr_chan  = 3'd0;
    bus4.wr_level = W4'(lvl);
    bus4.wr_mode  = 2'(md);
    @(negedge clk);
    bus4.wr_en    = 1'b0;
  endtask

  // Leaves the bench at a negedge where the next posedge is a tick edge.
  task automatic wait_tick_slot();
    int n;
    n = 0;
    while ((m_cyc % (1 << PRE)) != ((1 << PRE) - 1) && n < 8) begin
      @(negedge clk);
      n++;
    end
  endtask

  int exp_b [11] = '{1, 2, 3, 4, 5, 4, 3, 2, 1, 0, 1};

  // ---------------- directed sequence ----------------
  initial begin : main_seq
    int n, ones, rise_phase, prev, cur, k;
    int seq [11];
    logic pprev;

    bus.wr_en = 1'b0; bus.wr_chan = '0; bus.wr_level = '0; bus.wr_mode = '0;
    bus4.wr_en = 1'b0; bus4.wr_chan = '0; bus4.wr_level = '0; bus4.wr_mode = '0;

    // Reset held 5 clocks, then idle for 1000 clocks.
    repeat (5) @(negedge clk);
    chk("reset_pwm", int'(pwm), 0);
    chk("reset_level", int'(level), 0);
    chk("reset_settled", int'(settled), 7);
    resetq = 1'b1;
    repeat (1000) @(negedge clk);
    chk("idle_pwm", int'(pwm), 0);
    chk("idle_level", int'(level), 0);
    chk("idle_settled", int'(settled), 7);

    // FADE ch1 up to 10, then down to 3.
    wr(1, 10, 0);
    n = 1;
    while (int'(level[W +: W]) != 10 && n < 100) begin @(negedge clk); n++; end
    chk("fade_up_level", int'(level[W +: W]), 10);
    chk_range("fade_up_clks", n, 36, 44);
    chk("fade_up_settled", int'(settled[1]), 1);
    wr(1, 3, 0);
    n = 1;
    while (int'(level[W +: W]) != 3 && n < 100) begin @(negedge clk); n++; end
    chk("fade_down_level", int'(level[W +: W]), 3);
    chk_range("fade_down_clks", n, 24, 32);

    // SNAP ch0 to 64 and measure the duty cycle.
    wr(0, 64, 2);
    chk("snap_level", int'(level[7:0]), 64);
    ones = 0; rise_phase = -1; pprev = pwm[0];
    for (int c = 0; c < 256; c++) begin
      @(negedge clk);
      if (pwm[0]) ones++;
      if (pwm[0] && !pprev) rise_phase = m_cyc % 256;
      pprev = pwm[0];
    end
    chk("duty_high_clks", ones, 64);
    chk("pwm_rise_cnt_phase", rise_phase, 1);

    // BREATHE ch2 to 5 from level 0.
    wr(2, 5, 1);
    prev = 0; k = 0;
    for (int c = 0; c < 200 && k < 11; c++) begin
      @(negedge clk);
      chk("breathe_settled", int'(settled[2]), 0);
      cur = int'(level[2*W +: W]);
      if (cur != prev) begin seq[k] = cur; k++; prev = cur; end
    end
    chk("breathe_steps", k, 11);
    for (int j = 0; j < 11; j++) chk($sformatf("breathe_seq%0d", j), seq[j], exp_b[j]);
    wr(2, 0, 1);
    repeat (40) @(negedge clk);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("breathe_zero_level", int'(level[2*W +: W]), 0);
    end
    chk("breathe_zero_settled", int'(settled[2]), 0);

    // Collisions with a tick edge.
    wr(0, 0, 2);
    chk("snap_zero", int'(level[7:0]), 0);
    wait_tick_slot();
    wr(0, 7, 0);
    chk("collide_fade_no_step", int'(level[7:0]), 0);
    repeat (3) @(negedge clk);
    chk("collide_fade_before_tick", int'(level[7:0]), 0);
    @(negedge clk);
    chk("collide_fade_next_tick", int'(level[7:0]), 1);
    wait_tick_slot();
    wr(0, 200, 2);
    chk("collide_snap", int'(level[7:0]), 200);
    wr(5, 33, 1);
    repeat (8) @(negedge clk);
    chk("oob_level0", int'(level[7:0]), 200);
    chk("oob_level1", int'(level[W +: W]), 3);
    chk("oob_level2", int'(level[2*W +: W]), 0);
    chk("oob_settled", int'(settled), 3);

    // Mid-operation reset: pwm must drop without waiting for a clock.
    n = 0;
    while (pwm[0] !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    chk("pre_reset_pwm0", int'(pwm[0]), 1);
    #2 resetq = 1'b0;
    #1;
    chk("async_reset_pwm", int'(pwm), 0);
    chk("async_reset_level", int'(level), 0);
    chk("async_reset_settled", int'(settled), 7);
    chk("async_reset_level4", int'(level4), 0);
    repeat (2) @(negedge clk);
    resetq = 1'b1;

    // Saturation on the 4-bit instance.
    wr4(15, 0);
    prev = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      cur = int'(level4);
      chk_range("sat_up_step", cur - prev, 0, 1);
      prev = cur;
    end
    chk("sat_up_level", int'(level4), 15);
    chk("sat_up_settled", int'(settled4), 1);
    wr4(0, 0);
    prev = 15;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      cur = int'(level4);
      chk_range("sat_down_step", prev - cur, 0, 1);
      prev = cur;
    end
    chk("sat_down_level", int'(level4), 0);
    chk("sat_down_settled", int'(settled4), 1);
    chk("sat_down_pwm", int'(pwm4), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog: the sequence is a few thousand clocks long.
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
